// File: rtl/bram2_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with
// per-requester credit-guarded response FIFOs for read data.
module bram2_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned PIPELINED  = 1,
   parameter int unsigned RSP_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [DATA_WIDTH-1:0] rsp0_data,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp1_data,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_di,
   input  logic [DATA_WIDTH-1:0] bram_do
);
   localparam int unsigned LAT = (PIPELINED != 0) ? 2 : 1;
   localparam int unsigned PW  = $clog2(RSP_DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned SW  = CW + 1;

   logic [1:0]            req_valid, req_write, rsp_rdy, rsp_vld;
   logic [1:0]            elig, grant, issue, push, pop;
   logic [ADDR_WIDTH-1:0] req_addr  [2];
   logic [DATA_WIDTH-1:0] req_wdata [2];
   logic                  gid, rd_acc, last_grant;
   logic [1:0]            tag_valid, tag_id;
   logic [CW-1:0]         inflight [2];
   logic [CW-1:0]         count    [2];
   logic [SW-1:0]         occ      [2];
   logic [PW-1:0]         wr_ptr   [2];
   logic [PW-1:0]         rd_ptr   [2];
   logic [DATA_WIDTH-1:0] fifo_mem [2][RSP_DEPTH];

   assign req_valid    = {req1_valid, req0_valid};
   assign req_write    = {req1_write, req0_write};
   assign rsp_rdy      = {rsp1_ready, rsp0_ready};
   assign req_addr[0]  = req0_addr;
   assign req_addr[1]  = req1_addr;
   assign req_wdata[0] = req0_wdata;
   assign req_wdata[1] = req1_wdata;

   // A read is only eligible when its response is guaranteed a FIFO slot
   always_comb begin
      elig = '0;
      for (int n = 0; n < 2; n++) begin
         occ[n]  = {1'b0, count[n]} + {1'b0, inflight[n]};
         elig[n] = req_valid[n] & (req_write[n] | (occ[n] < SW'(RSP_DEPTH)));
      end
   end

   // Round-robin pick; reset forces no grant even before the first edge
   always_comb begin
      grant = '0;
      if (rst_n) begin
         if (elig == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
         else               grant = elig;
      end
   end

   assign gid        = grant[1];
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   always_comb begin
      bram_en   = |grant;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_di   = '0;
      if (bram_en) begin
         bram_we   = req_write[gid];
         bram_addr = req_addr[gid];
         bram_di   = req_wdata[gid];
      end
   end

   assign rd_acc  = bram_en & ~bram_we;
   assign issue   = {rd_acc & gid, rd_acc & ~gid};
   assign push    = {tag_valid[LAT-1] & tag_id[LAT-1], tag_valid[LAT-1] & ~tag_id[LAT-1]};
   assign rsp_vld = {count[1] != '0, count[0] != '0};
   assign pop     = rsp_vld & rsp_rdy;

   assign rsp0_valid = rsp_vld[0];
   assign rsp1_valid = rsp_vld[1];
   assign rsp0_data  = fifo_mem[0][rd_ptr[0]];
   assign rsp1_data  = fifo_mem[1][rd_ptr[1]];

   // Control state: grant history, read tags, credits and FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         tag_valid  <= '0;
         for (int n = 0; n < 2; n++) begin
            inflight[n] <= '0;
            count[n]    <= '0;
            wr_ptr[n]   <= '0;
            rd_ptr[n]   <= '0;
         end
      end else begin
         if (bram_en) last_grant <= gid;
         tag_valid <= {tag_valid[0], rd_acc};
         for (int n = 0; n < 2; n++) begin
            case ({issue[n], push[n]})
               2'b10:   inflight[n] <= inflight[n] + CW'(1);
               2'b01:   inflight[n] <= inflight[n] - CW'(1);
               default: ;
            endcase
            case ({push[n], pop[n]})
               2'b10:   count[n] <= count[n] + CW'(1);
               2'b01:   count[n] <= count[n] - CW'(1);
               default: ;
            endcase
            if (push[n]) wr_ptr[n] <= wr_ptr[n] + PW'(1);
            if (pop[n])  rd_ptr[n] <= rd_ptr[n] + PW'(1);
         end
      end
   end

   // Tag ids and FIFO storage carry no reset
   always_ff @(posedge clk) begin
      tag_id <= {tag_id[0], gid};
      for (int n = 0; n < 2; n++) begin
         if (push[n]) fifo_mem[n][wr_ptr[n]] <= bram_do;
      end
   end

   a_occ0: assert property (@(posedge clk) disable iff (!rst_n) occ[0] <= SW'(RSP_DEPTH));
   a_occ1: assert property (@(posedge clk) disable iff (!rst_n) occ[1] <= SW'(RSP_DEPTH));
endmodule

// File: tb/tb_bram2_port_arbiter.sv
// Directed bench: two arbiter instances (pipelined and non-pipelined BRAM)
// each backed by a write-first BRAM model.
module tb_bram2_port_arbiter;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic clk, clk_en, rst_n;
   int   errors, checks;

   logic          q0_valid, q0_ready, q0_write, q1_valid, q1_ready, q1_write;
   logic [AW-1:0] q0_addr, q1_addr;
   logic [DW-1:0] q0_wdata, q1_wdata;
   logic          p0_valid, p0_ready, p1_valid, p1_ready;
   logic [DW-1:0] p0_data, p1_data;
   logic          a_en, a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_di, a_do, a_do1, a_do2;
   logic [DW-1:0] mem_a [1024];

   logic          bq0_valid, bq0_ready, bq0_write, bq1_valid, bq1_ready, bq1_write;
   logic [AW-1:0] bq0_addr, bq1_addr;
   logic [DW-1:0] bq0_wdata, bq1_wdata;
   logic          bp0_valid, bp0_ready, bp1_valid, bp1_ready;
   logic [DW-1:0] bp0_data, bp1_data;
   logic          b_en, b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_di, b_do, b_do1;
   logic [DW-1:0] mem_b [1024];

   logic [DW-1:0] exp0[$];
   logic [DW-1:0] exp1[$];

   bram2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1), .RSP_DEPTH(4)) u_p1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_write(q0_write),
      .req0_addr(q0_addr), .req0_wdata(q0_wdata),
      .req1_valid(q1_valid), .req1_ready(q1_ready), .req1_write(q1_write),
      .req1_addr(q1_addr), .req1_wdata(q1_wdata),
      .rsp0_valid(p0_valid), .rsp0_ready(p0_ready), .rsp0_data(p0_data),
      .rsp1_valid(p1_valid), .rsp1_ready(p1_ready), .rsp1_data(p1_data),
      .bram_en(a_en), .bram_we(a_we), .bram_addr(a_addr), .bram_di(a_di), .bram_do(a_do)
   );

   bram2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(0), .RSP_DEPTH(4)) u_p0 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(bq0_valid), .req0_ready(bq0_ready), .req0_write(bq0_write),
      .req0_addr(bq0_addr), .req0_wdata(bq0_wdata),
      .req1_valid(bq1_valid), .req1_ready(bq1_ready), .req1_write(bq1_write),
      .req1_addr(bq1_addr), .req1_wdata(bq1_wdata),
      .rsp0_valid(bp0_valid), .rsp0_ready(bp0_ready), .rsp0_data(bp0_data),
      .rsp1_valid(bp1_valid), .rsp1_ready(bp1_ready), .rsp1_data(bp1_data),
      .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_di(b_di), .bram_do(b_do)
   );

   // Write-first BRAM models: two-stage read for u_p1, one-stage for u_p0
   always @(posedge clk) begin
      if (a_en) begin
         if (a_we) begin mem_a[a_addr] <= a_di; a_do1 <= a_di; end
         else a_do1 <= mem_a[a_addr];
      end
      a_do2 <= a_do1;
      if (b_en) begin
         if (b_we) begin mem_b[b_addr] <= b_di; b_do1 <= b_di; end
         else b_do1 <= mem_b[b_addr];
      end
   end
   assign a_do = a_do2;
   assign b_do = b_do1;

   always #5 if (clk_en) clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mon();
      if (p0_valid && p0_ready) begin
         chk("rsp0_pending", 32'(exp0.size() != 0), 1);
         if (exp0.size() != 0) chk("rsp0_data", p0_data, exp0.pop_front());
      end
      if (p1_valid && p1_ready) begin
         chk("rsp1_pending", 32'(exp1.size() != 0), 1);
         if (exp1.size() != 0) chk("rsp1_data", p1_data, exp1.pop_front());
      end
   endtask

   initial begin
      int a0, a1;
      logic g1, ev;
      errors = 0; checks = 0;
      clk = 1'b0; clk_en = 1'b0; rst_n = 1'b1;
      q0_valid = 0; q0_write = 0; q0_addr = '0; q0_wdata = '0;
      q1_valid = 0; q1_write = 0; q1_addr = '0; q1_wdata = '0;
      p0_ready = 1; p1_ready = 1;
      bq0_valid = 0; bq0_write = 0; bq0_addr = '0; bq0_wdata = '0;
      bq1_valid = 0; bq1_write = 0; bq1_addr = '0; bq1_wdata = '0;
      bp0_ready = 1; bp1_ready = 1;

      // 1: asynchronous reset with the clock stopped
      #1; rst_n = 1'b0; q0_valid = 1; bq0_valid = 1;
      #1;
      chk("rst_ready0", q0_ready, 0);
      chk("rst_en", a_en, 0);
      chk("rst_rsp0v", p0_valid, 0);
      chk("rst_b_ready0", bq0_ready, 0);
      chk("rst_b_en", b_en, 0);
      q0_valid = 0; bq0_valid = 0; clk_en = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      #1 chk("idle_en", a_en, 0);

      // 2: write then read of the same address from different ports
      q0_valid = 1; q0_write = 1; q0_addr = 10'd5; q0_wdata = 32'hDEADBEEF;
      #1;
      chk("wr_ready0", q0_ready, 1);
      chk("wr_we", a_we, 1);
      chk("wr_addr", a_addr, 5);
      chk("wr_di", a_di, 32'hDEADBEEF);
      tick();
      q0_valid = 0; q0_write = 0; q1_valid = 1; q1_write = 0; q1_addr = 10'd5;
      #1;
      chk("rd_ready1", q1_ready, 1);
      chk("rd_we", a_we, 0);
      tick();
      q1_valid = 0;
      #1 chk("lat_t1_rsp1v", p1_valid, 0);
      tick();
      #1 chk("lat_t2_rsp1v", p1_valid, 0);
      tick();
      #1;
      chk("lat_t3_rsp1v", p1_valid, 1);
      chk("lat_t3_data", p1_data, 32'hDEADBEEF);
      chk("lat_t3_rsp0v", p0_valid, 0);
      tick();
      #1;
      chk("lat_t4_rsp1v", p1_valid, 0);
      chk("lat_t4_rsp0v", p0_valid, 0);

      // Preload addresses 0..7 through requester 0
      for (int i = 0; i < 8; i++) begin
         q0_valid = 1; q0_write = 1; q0_addr = AW'(i); q0_wdata = 32'hA000_0000 + 32'(i);
         #1 chk("pre_ready0", q0_ready, 1);
         tick();
      end
      q0_valid = 0; q0_write = 0;

      // 3: both requesters stream reads; last grant was port 0
      a0 = 0; a1 = 4;
      q0_valid = 1; q1_valid = 1;
      for (int k = 0; k < 8; k++) begin
         q0_addr = AW'(a0); q1_addr = AW'(a1);
         #1;
         g1 = (k % 2 == 0);
         chk("rr_ready0", q0_ready, !g1);
         chk("rr_ready1", q1_ready, g1);
         chk("rr_en", a_en, 1);
         chk("rr_addr", a_addr, 32'(g1 ? a1 : a0));
         mon();
         if (g1) begin exp1.push_back(32'hA000_0000 + 32'(a1)); a1++; end
         else    begin exp0.push_back(32'hA000_0000 + 32'(a0)); a0++; end
         tick();
      end
      q0_valid = 0; q1_valid = 0;
      for (int k = 0; k < 5; k++) begin #1 mon(); tick(); end
      chk("rr_drained", 32'(exp0.size() + exp1.size()), 0);

      // 4: requester 0 stalls on credit while requester 1 keeps going
      a0 = 0; p0_ready = 0;
      q0_valid = 1; q1_valid = 1; q1_addr = 10'd7;
      for (int k = 0; k < 12; k++) begin
         q0_addr = AW'(a0);
         #1;
         g1 = (k >= 8) || (k % 2 == 0);
         chk("cr_ready0", q0_ready, !g1);
         chk("cr_ready1", q1_ready, g1);
         mon();
         if (g1) exp1.push_back(32'hA000_0007);
         else begin exp0.push_back(32'hA000_0000 + 32'(a0)); a0++; end
         tick();
      end
      q1_valid = 0; q0_addr = AW'(a0); p0_ready = 1;
      #1;
      chk("cr_full_ready0", q0_ready, 0);
      chk("cr_full_rsp0v", p0_valid, 1);
      mon();
      tick();
      for (int j = 0; j < 4; j++) begin
         q0_addr = AW'(a0);
         #1;
         chk("cr_resume_ready0", q0_ready, 1);
         mon();
         exp0.push_back(32'hA000_0000 + 32'(a0)); a0++;
         tick();
      end
      q0_valid = 0;
      for (int k = 0; k < 8; k++) begin #1 mon(); tick(); end
      chk("cr_drained", 32'(exp0.size() + exp1.size()), 0);

      // 5: non-pipelined BRAM, continuous reads with same-cycle push/pop
      bq0_valid = 1; bq0_write = 1; bq0_addr = 10'd3; bq0_wdata = 32'h3333_0003;
      #1 chk("np_wr3_ready", bq0_ready, 1);
      tick();
      bq0_addr = 10'd4; bq0_wdata = 32'h4444_0004;
      #1 chk("np_wr4_ready", bq0_ready, 1);
      tick();
      bq0_write = 0;
      for (int k = 0; k < 9; k++) begin
         bq0_valid = (k < 6);
         bq0_addr  = (k % 2 == 0) ? 10'd3 : 10'd4;
         #1;
         chk("np_ready0", bq0_ready, k < 6);
         ev = (k >= 2) && (k < 8);
         chk("np_rsp0v", bp0_valid, ev);
         if (ev) chk("np_data", bp0_data, ((k - 2) % 2 == 0) ? 32'h3333_0003 : 32'h4444_0004);
         tick();
      end

      // 6: reset with two reads in flight
      q0_valid = 1; q0_addr = 10'd1;
      #1 chk("rf_ready0", q0_ready, 1);
      tick();
      q0_valid = 0; q1_valid = 1; q1_addr = 10'd2;
      #1 chk("rf_ready1", q1_ready, 1);
      tick();
      q1_valid = 0;
      #1 rst_n = 1'b0;
      #1;
      chk("rf_rst_en", a_en, 0);
      chk("rf_rst_rsp0v", p0_valid, 0);
      chk("rf_rst_rsp1v", p1_valid, 0);
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rf_post_rsp0v", p0_valid, 0);
         chk("rf_post_rsp1v", p1_valid, 0);
         tick();
      end
      q0_valid = 1; q0_addr = 10'd6;
      #1 chk("rf_new_ready0", q0_ready, 1);
      tick();
      q0_valid = 0;
      #1 chk("rf_new_t1", p0_valid, 0);
      tick();
      #1 chk("rf_new_t2", p0_valid, 0);
      tick();
      #1;
      chk("rf_new_t3", p0_valid, 1);
      chk("rf_new_data", p0_data, 32'hA000_0006);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
